mem_rr_scheduler: RTL and testbench
===================================

# mem_rr_scheduler

Time-multiplexes the single host memory controller between up to four requesters: CPU fetch, CPU data, FPU MMIO control, and a spare. Each requester uses the controller's op/address/data handshake. The block holds one transaction in flight, forwards completion strobes back to the owner, and chooses the next owner round-robin. It sits between the requesters and `mem_ctrl`, in the AFU top level.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesters (2..4).
- `ADDR_WIDTH`, 64: byte address width.
- `DATA_WIDTH`, 512: cache-line data width.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `op_src`  in  [NUM_SRC][2]  per-source op: 00 idle, 01 read, 10 write, 11 reserved (ignored).
- `raw_address_src`  in  [NUM_SRC][ADDR_WIDTH]  per-source address.
- `wr_data_src`  in  [NUM_SRC][DATA_WIDTH]  per-source write data.
- `rd_data_src`  out  DATA_WIDTH  read data, broadcast to all sources.
- `tx_done_src`  out  [NUM_SRC]  completion strobe, owner only.
- `rd_valid_src`  out  [NUM_SRC]  read-data-valid strobe, owner only.
- `ready`  in  1  `mem_ctrl` can accept an op.
- `tx_done`  in  1  `mem_ctrl` transaction complete (1-cycle pulse).
- `rd_valid`  in  1  `mem_ctrl` read data valid.
- `common_data_bus_write_out`  in  DATA_WIDTH  read data from `mem_ctrl`.
- `op`  out  2  op to `mem_ctrl`.
- `raw_address`  out  ADDR_WIDTH  address to `mem_ctrl`.
- `common_data_bus_read_in`  out  DATA_WIDTH  write data to `mem_ctrl`.
- `busy`  out  1  transaction in flight.
- `grant_id`  out  2  current or last owner index.

## Operation
- States:
  - IDLE: `op` = 00. If `ready`=1 and any source has op 01 or 10, pick a winner, latch its op/address/data and the grant, then go to WAIT. Otherwise stay.
  - WAIT: drive the latched op/address/data, held stable. On `tx_done`=1, return to IDLE.
- Round-robin:
  - Pointer `ptr` = last winner + 1, modulo NUM_SRC.
  - The search starts at `ptr`; the first requesting source wins.
  - `ptr` updates only on grant.
- Routing:
  - `tx_done_src[g]` = `tx_done` & WAIT.
  - `rd_valid_src[g]` = `rd_valid` & WAIT.
  - All non-owner strobes are 0.
  - `rd_data_src` = `common_data_bus_write_out`, unregistered.
- Requester rule: hold op until `tx_done_src` is seen. Any op still present in the cycle after `tx_done_src` is treated as a new request.
- Reserved op 11 is never granted. Requests from source indices ≥ NUM_SRC are ignored.
- `rd_valid` or `tx_done` arriving in IDLE is dropped, and no source strobes.
- Simultaneous `tx_done` and a new request: the new request is arbitrated in the following IDLE cycle, never in the same cycle.

## Timing
- Reset values:
  - `op`=00, `raw_address`=0, `common_data_bus_read_in`=0.
  - `busy`=0, `grant_id`=0, `ptr`=0, state IDLE.
  - All `*_src` strobes 0.
- Grant latency: request sampled in IDLE at edge N means `op` is valid on `mem_ctrl` from cycle N+1.
- Completion: `tx_done` in cycle M gives `tx_done_src[g]` in cycle M with 0 latency, IDLE at M+1, next op earliest at M+2. There is one mandatory idle bubble.
- `busy` = 1 exactly while in WAIT.
- `grant_id` updates at the grant edge and holds through the following IDLE.
- Reset mid-transaction abandons it: outputs go to reset values immediately, with no strobe to the owner.

## Configuration
- `MEM_SCHED_FIXED_PRIO_EN` defined: fixed priority, source 0 highest, `ptr` unused and held at 0.
- Undefined (default): round-robin as above.

## Structure
- Package `mem_sched_pkg`:
  - `mem_op_t` enum (MEM_IDLE=2'b00, MEM_READ=2'b01, MEM_WRITE=2'b10).
  - `sched_state_t` enum (IDLE, WAIT).
  - `MAX_SRC`=4.
- Sub-module `rr_pick`: combinational request-vector + pointer → one-hot grant and index. The fixed-priority variant is selected inside it by the macro.

## Test plan
- Single read, src1, addr 0x40: `op`=01 and `raw_address`=0x40 at N+1. `tx_done`+`rd_valid` with data 0xA5.. at M gives `tx_done_src`=0010, `rd_valid_src`=0010, `rd_data_src`=0xA5..; IDLE at M+1.
- All four sources issue write requests continuously from reset: grant order 0,1,2,3,0. With the macro defined: 0,0,0.
- `ready`=0 for 5 cycles with src2 requesting: `op` stays 00 and `busy`=0. Grant issues the cycle after `ready`=1.
- Src0 holds op one cycle after `tx_done_src`: treated as a new request, granted only if it is next round-robin (src1 requesting wins first).
- Spurious `tx_done` in IDLE: all `tx_done_src`=0 and state unchanged. Op 11 on src3 alone: never granted.
- `rst_n` low mid-WAIT: `op`=00, `busy`=0, `grant_id`=0 asynchronously. Next request after release is granted from `ptr`=0.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the memory-controller request scheduler.
package mem_sched_pkg;

  localparam int unsigned MAX_SRC   = 4;
  localparam int unsigned SRC_IDX_W = 2;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } sched_state_t;

  // Only read and write count as requests; idle and the reserved code do not.
  function automatic logic is_req(input logic [1:0] op);
    return (op == 2'b01) || (op == 2'b10);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: round-robin from ptr, or fixed priority
// (source 0 highest, next_ptr held at 0) when MEM_SCHED_FIXED_PRIO_EN is defined.
module rr_pick
  import mem_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [MAX_SRC-1:0]   req,
  input  logic [SRC_IDX_W-1:0] ptr,
  output logic [MAX_SRC-1:0]   gnt_c,
  output logic [SRC_IDX_W-1:0] idx_c,
  output logic                 valid_c,
  output logic [SRC_IDX_W-1:0] next_ptr_c
);

  always_comb begin
    gnt_c      = '0;
    idx_c      = '0;
    valid_c    = 1'b0;
    next_ptr_c = '0;
`ifdef MEM_SCHED_FIXED_PRIO_EN
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!valid_c && req[k]) begin
        valid_c = 1'b1;
        idx_c   = SRC_IDX_W'(k);
      end
    end
`else
    // Walk the sources starting at ptr, wrapping at NUM_SRC.
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!valid_c && req[SRC_IDX_W'((32'(ptr) + k) % NUM_SRC)]) begin
        valid_c = 1'b1;
        idx_c   = SRC_IDX_W'((32'(ptr) + k) % NUM_SRC);
      end
    end
    next_ptr_c = (32'(idx_c) + 32'd1 == NUM_SRC) ? '0 : idx_c + SRC_IDX_W'(1);
`endif
    gnt_c[idx_c] = valid_c;
  end

endmodule

// File: rtl/mem_rr_scheduler.sv
// Shares one mem_ctrl between up to four requesters, one transaction in flight.
// Arbitration policy is chosen in rr_pick via MEM_SCHED_FIXED_PRIO_EN.
module mem_rr_scheduler
  import mem_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 512
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_SRC-1:0][1:0]              op_src,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]   raw_address_src,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   wr_data_src,
  output logic [DATA_WIDTH-1:0]                rd_data_src,
  output logic [NUM_SRC-1:0]                   tx_done_src,
  output logic [NUM_SRC-1:0]                   rd_valid_src,
  input  logic                                 ready,
  input  logic                                 tx_done,
  input  logic                                 rd_valid,
  input  logic [DATA_WIDTH-1:0]                common_data_bus_write_out,
  output logic [1:0]                           op,
  output logic [ADDR_WIDTH-1:0]                raw_address,
  output logic [DATA_WIDTH-1:0]                common_data_bus_read_in,
  output logic                                 busy,
  output logic [1:0]                           grant_id
);

  sched_state_t           state_q, state_d;
  logic [SRC_IDX_W-1:0]   ptr_q, grant_q;
  logic [1:0]             op_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;

  logic [MAX_SRC-1:0]     req;
  logic [MAX_SRC-1:0]     gnt_c;
  logic [SRC_IDX_W-1:0]   idx_c, next_ptr_c;
  logic                   valid_c;
  logic                   grant_en, done_en;
  logic [1:0]             sel_op;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_data;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_SRC; i++) req[i] = is_req(op_src[i]);
  end

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .gnt_c      (gnt_c),
    .idx_c      (idx_c),
    .valid_c    (valid_c),
    .next_ptr_c (next_ptr_c)
  );

  // One-hot AND-OR mux of the winner's payload.
  always_comb begin
    sel_op   = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_c[i]) begin
        sel_op   = sel_op   | op_src[i];
        sel_addr = sel_addr | raw_address_src[i];
        sel_data = sel_data | wr_data_src[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Completion and new arbitration never share a cycle: WAIT only looks at tx_done.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    done_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready && valid_c) begin
          grant_en = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          done_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 2'b00;
      addr_q  <= '0;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else if (grant_en) begin
      op_q    <= sel_op;
      addr_q  <= sel_addr;
      data_q  <= sel_data;
      grant_q <= idx_c;
      ptr_q   <= next_ptr_c;
    end else if (done_en) begin
      op_q    <= 2'b00;
    end
  end

  // Strobes are steered to the owner only while a transaction is in flight.
  always_comb begin
    tx_done_src  = '0;
    rd_valid_src = '0;
    if (state_q == WAIT) begin
      tx_done_src[grant_q]  = tx_done;
      rd_valid_src[grant_q] = rd_valid;
    end
  end

  assign rd_data_src             = common_data_bus_write_out;
  assign op                      = op_q;
  assign raw_address             = addr_q;
  assign common_data_bus_read_in = data_q;
  assign busy                    = (state_q == WAIT);
  assign grant_id                = grant_q;

endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Directed self-checking bench for mem_rr_scheduler; inputs driven and outputs
// sampled on the falling clock edge.
module tb_mem_rr_scheduler;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0][1:0]   op_src;
  logic [3:0][63:0]  addr_src;
  logic [3:0][511:0] wd_src;
  logic [511:0]      rd_data_src;
  logic [3:0]        tx_done_src, rd_valid_src;
  logic              ready, tx_done, rd_valid;
  logic [511:0]      mem_rdata;
  logic [1:0]        op;
  logic [63:0]       raw_address;
  logic [511:0]      wdata_out;
  logic              busy;
  logic [1:0]        grant_id;

  int tests = 0;
  int fails = 0;

  mem_rr_scheduler #(.NUM_SRC(4), .ADDR_WIDTH(64), .DATA_WIDTH(512)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .op_src                    (op_src),
    .raw_address_src           (addr_src),
    .wr_data_src               (wd_src),
    .rd_data_src               (rd_data_src),
    .tx_done_src               (tx_done_src),
    .rd_valid_src              (rd_valid_src),
    .ready                     (ready),
    .tx_done                   (tx_done),
    .rd_valid                  (rd_valid),
    .common_data_bus_write_out (mem_rdata),
    .op                        (op),
    .raw_address               (raw_address),
    .common_data_bus_read_in   (wdata_out),
    .busy                      (busy),
    .grant_id                  (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset;
    rst_n = 1'b0;
    op_src = '0; addr_src = '0; wd_src = '0;
    ready = 1'b1; tx_done = 1'b0; rd_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    op_src = '0; addr_src = '0; wd_src = '0;
    ready = 1'b1; tx_done = 1'b0; rd_valid = 1'b0; mem_rdata = '0;
    op_src[0] = 2'b01; addr_src[0] = 64'h55;
    repeat (2) @(negedge clk);
    tests++; if (op !== 2'b00) begin fails++; $display("FAIL reset_op: got %0h want 0", op); end
    tests++; if (raw_address !== 64'h0) begin fails++; $display("FAIL reset_addr: got %0h want 0", raw_address); end
    tests++; if (wdata_out !== 512'h0) begin fails++; $display("FAIL reset_wdata: got nonzero want 0"); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    tests++; if ({tx_done_src, rd_valid_src} !== 8'h00) begin fails++; $display("FAIL reset_strobes: got %0h want 0", {tx_done_src, rd_valid_src}); end
    op_src = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read;
    logic [511:0] pat;
    pat = {16{32'hA5A5A5A5}};
    op_src[1] = 2'b01; addr_src[1] = 64'h40;
    @(negedge clk);
    tests++; if (op !== 2'b01) begin fails++; $display("FAIL rd_op: got %0h want 1", op); end
    tests++; if (raw_address !== 64'h40) begin fails++; $display("FAIL rd_addr: got %0h want 40", raw_address); end
    tests++; if (busy !== 1'b1 || grant_id !== 2'd1) begin fails++; $display("FAIL rd_grant: got busy=%0b id=%0d want busy=1 id=1", busy, grant_id); end
    addr_src[1] = 64'h80;
    @(negedge clk);
    tests++; if (raw_address !== 64'h40) begin fails++; $display("FAIL rd_addr_hold: got %0h want 40", raw_address); end
    tx_done = 1'b1; rd_valid = 1'b1; mem_rdata = pat;
    #1;
    tests++; if (tx_done_src !== 4'b0010) begin fails++; $display("FAIL rd_tx_done_src: got %b want 0010", tx_done_src); end
    tests++; if (rd_valid_src !== 4'b0010) begin fails++; $display("FAIL rd_valid_src: got %b want 0010", rd_valid_src); end
    tests++; if (rd_data_src !== pat) begin fails++; $display("FAIL rd_data: got %0h want %0h", rd_data_src[31:0], pat[31:0]); end
    @(negedge clk);
    tx_done = 1'b0; rd_valid = 1'b0; op_src[1] = 2'b00;
    #1;
    tests++; if (busy !== 1'b0 || op !== 2'b00) begin fails++; $display("FAIL rd_idle_after: got busy=%0b op=%0h want 0/0", busy, op); end
    tests++; if (grant_id !== 2'd1) begin fails++; $display("FAIL rd_grant_hold: got %0d want 1", grant_id); end
    @(negedge clk);
  endtask

  task automatic test_rr_order;
    int exp_id[5];
`ifdef MEM_SCHED_FIXED_PRIO_EN
    exp_id = '{0, 0, 0, 0, 0};
`else
    exp_id = '{0, 1, 2, 3, 0};
`endif
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      op_src[i]   = 2'b10;
      addr_src[i] = 64'h100 * 64'(i + 1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++; if (busy !== 1'b1 || grant_id !== 2'(exp_id[k])) begin fails++; $display("FAIL rr_grant%0d: got busy=%0b id=%0d want busy=1 id=%0d", k, busy, grant_id, exp_id[k]); end
      tests++; if (op !== 2'b10 || raw_address !== 64'h100 * 64'(exp_id[k] + 1)) begin fails++; $display("FAIL rr_payload%0d: got op=%0h addr=%0h want op=2", k, op, raw_address); end
      tx_done = 1'b1;
      #1;
      tests++; if (tx_done_src !== 4'(1 << exp_id[k])) begin fails++; $display("FAIL rr_done%0d: got %b want one-hot %0d", k, tx_done_src, exp_id[k]); end
      @(negedge clk);
      tx_done = 1'b0;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_bubble%0d: got busy=%0b want 0", k, busy); end
      if (k == 4) op_src = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_ready_low;
    apply_reset();
    ready = 1'b0;
    op_src[2] = 2'b01; addr_src[2] = 64'h200;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++; if (op !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL notready%0d: got op=%0h busy=%0b want 0/0", k, op, busy); end
    end
    ready = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b1 || grant_id !== 2'd2 || op !== 2'b01) begin fails++; $display("FAIL ready_grant: got busy=%0b id=%0d op=%0h want 1/2/1", busy, grant_id, op); end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0; op_src[2] = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_hold_after_done;
    logic [1:0] exp_id;
`ifdef MEM_SCHED_FIXED_PRIO_EN
    exp_id = 2'd0;
`else
    exp_id = 2'd1;
`endif
    op_src[0] = 2'b01; addr_src[0] = 64'h10;
    @(negedge clk);
    tests++; if (busy !== 1'b1 || grant_id !== 2'd0) begin fails++; $display("FAIL hold_first: got busy=%0b id=%0d want 1/0", busy, grant_id); end
    op_src[1] = 2'b10; addr_src[1] = 64'h20;
    @(negedge clk);
    tx_done = 1'b1;
    #1;
    tests++; if (tx_done_src !== 4'b0001) begin fails++; $display("FAIL hold_done: got %b want 0001", tx_done_src); end
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    op_src[0] = 2'b00;
    tests++; if (busy !== 1'b1 || grant_id !== exp_id) begin fails++; $display("FAIL hold_regrant: got busy=%0b id=%0d want 1/%0d", busy, grant_id, exp_id); end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0; op_src[1] = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_spurious;
    tx_done = 1'b1; rd_valid = 1'b1;
    #1;
    tests++; if (tx_done_src !== 4'b0000 || rd_valid_src !== 4'b0000) begin fails++; $display("FAIL spurious_strobe: got %b/%b want 0000/0000", tx_done_src, rd_valid_src); end
    @(negedge clk);
    tx_done = 1'b0; rd_valid = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL spurious_state: got busy=%0b want 0", busy); end
    op_src[3] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++; if (busy !== 1'b0 || op !== 2'b00) begin fails++; $display("FAIL reserved%0d: got busy=%0b op=%0h want 0/0", k, busy, op); end
    end
    op_src[3] = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait;
    op_src[1] = 2'b01; addr_src[1] = 64'h11;
    @(negedge clk);
    tests++; if (busy !== 1'b1 || grant_id !== 2'd1) begin fails++; $display("FAIL midrst_pre: got busy=%0b id=%0d want 1/1", busy, grant_id); end
    #2 rst_n = 1'b0; tx_done = 1'b1;
    #1;
    tests++; if (op !== 2'b00 || busy !== 1'b0 || grant_id !== 2'd0) begin fails++; $display("FAIL midrst_async: got op=%0h busy=%0b id=%0d want 0/0/0", op, busy, grant_id); end
    tests++; if (tx_done_src !== 4'b0000) begin fails++; $display("FAIL midrst_strobe: got %b want 0000", tx_done_src); end
    op_src[1] = 2'b00;
    @(negedge clk);
    rst_n = 1'b1; tx_done = 1'b0;
    op_src[1] = 2'b01; op_src[2] = 2'b01;
    addr_src[1] = 64'h11; addr_src[2] = 64'h22;
    @(negedge clk);
    tests++; if (grant_id !== 2'd1 || raw_address !== 64'h11) begin fails++; $display("FAIL midrst_ptr0: got id=%0d addr=%0h want 1/11", grant_id, raw_address); end
    op_src = '0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_order();
    test_ready_low();
    test_hold_after_done();
    test_spurious();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
